// File: rtl/elevator_scheduler.sv
// SCAN elevator scheduler: latches hall/cabin calls, picks travel direction,
// decides stops on arrival and times the door dwell. All outputs are registered.
module elevator_scheduler #(
  parameter int FLOORS     = 8,
  parameter int FLOOR_W    = 3,
  parameter int DOOR_TICKS = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req_valid,
  input  logic [FLOOR_W-1:0] req_floor,
  input  logic [1:0]         req_type,
  input  logic [FLOOR_W-1:0] cur_floor,
  input  logic               arrive,
  output logic [FLOORS-1:0]  call_inside,
  output logic [FLOORS-1:0]  call_up,
  output logic [FLOORS-1:0]  call_down,
  output logic               should_move,
  output logic               direction,
  output logic               door_open,
  output logic [1:0]         state_out
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_MOVING = 2'd1,
    S_DOOR   = 2'd2
  } state_t;

  localparam int                 CNT_W    = $clog2(DOOR_TICKS + 1);
  localparam logic [CNT_W-1:0]   CNT_LOAD = CNT_W'(DOOR_TICKS);
  localparam logic [CNT_W-1:0]   CNT_ONE  = CNT_W'(1);
  localparam logic [FLOOR_W-1:0] TOP_FLR  = FLOOR_W'(FLOORS - 1);
  localparam logic [FLOOR_W-1:0] BOT_FLR  = FLOOR_W'(0);

  state_t             r_state;
  logic [FLOORS-1:0]  r_call_in;
  logic [FLOORS-1:0]  r_call_up;
  logic [FLOORS-1:0]  r_call_dn;
  logic               r_should_move;
  logic               r_dir;
  logic               r_door;
  logic [CNT_W-1:0]   r_cnt;

  logic [FLOORS-1:0]  w_above_m;
  logic [FLOORS-1:0]  w_below_m;
  logic [FLOORS-1:0]  w_at_m;
  logic [FLOORS-1:0]  w_req_m;
  logic [FLOORS-1:0]  w_all;
  logic               w_any;
  logic               w_ahead;
  logic               w_at_in;
  logic               w_at_up;
  logic               w_at_dn;
  logic               w_at_any;
  logic               w_match;
  logic               w_opp;
  logic               w_req_ok;
  logic               w_req_here;
  logic               w_req_lat;
  logic               w_enter_door;
  logic               w_flip;
  logic [FLOORS-1:0]  w_set_in;
  logic [FLOORS-1:0]  w_set_up;
  logic [FLOORS-1:0]  w_set_dn;
  logic [FLOORS-1:0]  w_clr_in;
  logic [FLOORS-1:0]  w_clr_up;
  logic [FLOORS-1:0]  w_clr_dn;

  // Floor masks relative to the cabin and to the incoming request.
  always_comb begin
    w_above_m = '0;
    w_below_m = '0;
    w_at_m    = '0;
    w_req_m   = '0;
    for (int i = 0; i < FLOORS; i++) begin
      w_above_m[i] = (FLOOR_W'(i) > cur_floor);
      w_below_m[i] = (FLOOR_W'(i) < cur_floor);
      w_at_m[i]    = (FLOOR_W'(i) == cur_floor);
      w_req_m[i]   = (FLOOR_W'(i) == req_floor);
    end
  end

  // Pending summaries, stop decision and call set/clear masks.
  always_comb begin
    w_all    = r_call_in | r_call_up | r_call_dn;
    w_any    = |w_all;
    w_ahead  = r_dir ? (|(w_all & w_above_m)) : (|(w_all & w_below_m));
    w_at_in  = |(r_call_in & w_at_m);
    w_at_up  = |(r_call_up & w_at_m);
    w_at_dn  = |(r_call_dn & w_at_m);
    w_at_any = w_at_in | w_at_up | w_at_dn;
    w_match  = r_dir ? w_at_up : w_at_dn;
    w_opp    = r_dir ? w_at_dn : w_at_up;

    w_req_ok = req_valid && (|w_req_m) && (req_type != 2'd3)
               && !((req_type == 2'd1) && (req_floor == TOP_FLR))
               && !((req_type == 2'd2) && (req_floor == BOT_FLR));
    w_req_here = w_req_ok && (r_state == S_DOOR) && (req_floor == cur_floor);
    w_req_lat  = w_req_ok && !w_req_here;
    w_set_in = (w_req_lat && (req_type == 2'd0)) ? w_req_m : '0;
    w_set_up = (w_req_lat && (req_type == 2'd1)) ? w_req_m : '0;
    w_set_dn = (w_req_lat && (req_type == 2'd2)) ? w_req_m : '0;

    w_enter_door = ((r_state == S_IDLE) && w_at_any)
                   || ((r_state == S_MOVING) && arrive
                       && (w_at_in || w_match || (!w_ahead && w_at_any)));
    // An idle cabin serving only an opposite hall call turns to match it,
    // otherwise that call would reopen the door forever.
    w_flip = !w_ahead || ((r_state == S_IDLE) && w_opp && !w_match);
    w_clr_in = w_enter_door ? w_at_m : '0;
    w_clr_up = (w_enter_door && (r_dir || w_flip)) ? w_at_m : '0;
    w_clr_dn = (w_enter_door && (!r_dir || w_flip)) ? w_at_m : '0;
  end

  // Scheduler FSM, call vectors and door dwell counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_call_in     <= '0;
      r_call_up     <= '0;
      r_call_dn     <= '0;
      r_should_move <= 1'b0;
      r_dir         <= 1'b1;
      r_door        <= 1'b0;
      r_cnt         <= '0;
    end else begin
      r_call_in <= (r_call_in | w_set_in) & ~w_clr_in;
      r_call_up <= (r_call_up | w_set_up) & ~w_clr_up;
      r_call_dn <= (r_call_dn | w_set_dn) & ~w_clr_dn;
      case (r_state)
        S_IDLE: begin
          if (!w_any) begin
            r_should_move <= 1'b0;
          end else if (w_enter_door) begin
            r_state       <= S_DOOR;
            r_should_move <= 1'b0;
            r_door        <= 1'b1;
            r_cnt         <= CNT_LOAD;
            r_dir         <= r_dir ^ w_flip;
          end else if (w_ahead) begin
            r_state       <= S_MOVING;
            r_should_move <= 1'b1;
          end else begin
            r_state       <= S_MOVING;
            r_should_move <= 1'b1;
            r_dir         <= ~r_dir;
          end
        end
        S_MOVING: begin
          if (w_enter_door) begin
            r_state       <= S_DOOR;
            r_should_move <= 1'b0;
            r_door        <= 1'b1;
            r_cnt         <= CNT_LOAD;
            r_dir         <= r_dir ^ w_flip;
          end else begin
            r_should_move <= 1'b1;
          end
        end
        S_DOOR: begin
          if (w_req_here) begin
            r_cnt <= CNT_LOAD;
          end else if (r_cnt <= CNT_ONE) begin
            r_state <= S_IDLE;
            r_door  <= 1'b0;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt - CNT_ONE;
          end
        end
        default: begin
          r_state       <= S_IDLE;
          r_should_move <= 1'b0;
          r_door        <= 1'b0;
          r_cnt         <= '0;
        end
      endcase
    end
  end

  assign call_inside = r_call_in;
  assign call_up     = r_call_up;
  assign call_down   = r_call_dn;
  assign should_move = r_should_move;
  assign direction   = r_dir;
  assign door_open   = r_door;
  assign state_out   = r_state;

endmodule

// File: tb/tb_elevator_scheduler.sv
// Directed self-checking bench for elevator_scheduler; FLOOR_W=4 so that an
// out-of-range floor (9) can be requested.
module tb_elevator_scheduler;

  localparam int FLOORS = 8;
  localparam int FLOOR_W = 4;
  localparam int DOOR_TICKS = 4;

  logic               clk;
  logic               reset;
  logic               req_valid;
  logic [FLOOR_W-1:0] req_floor;
  logic [1:0]         req_type;
  logic [FLOOR_W-1:0] cur_floor;
  logic               arrive;
  logic [FLOORS-1:0]  call_inside;
  logic [FLOORS-1:0]  call_up;
  logic [FLOORS-1:0]  call_down;
  logic               should_move;
  logic               direction;
  logic               door_open;
  logic [1:0]         state_out;

  int n_checks = 0;
  int n_fail = 0;

  elevator_scheduler #(
    .FLOORS(FLOORS), .FLOOR_W(FLOOR_W), .DOOR_TICKS(DOOR_TICKS)
  ) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_floor(req_floor),
    .req_type(req_type), .cur_floor(cur_floor), .arrive(arrive),
    .call_inside(call_inside), .call_up(call_up), .call_down(call_down),
    .should_move(should_move), .direction(direction), .door_open(door_open),
    .state_out(state_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic req(input int f, input int t);
    req_valid = 1'b1;
    req_floor = FLOOR_W'(f);
    req_type  = 2'(t);
    tick();
    req_valid = 1'b0;
  endtask

  task automatic arr(input int f);
    cur_floor = FLOOR_W'(f);
    arrive = 1'b1;
    tick();
    arrive = 1'b0;
  endtask

  initial begin
    req_valid = 1'b0;
    req_floor = '0;
    req_type  = 2'd0;
    cur_floor = '0;
    arrive    = 1'b0;
    do_reset();

    // Reset state
    check_eq("rst_state", 32'(state_out), 32'd0);
    check_eq("rst_calls", 32'(call_inside | call_up | call_down), 32'd0);
    check_eq("rst_dir", 32'(direction), 32'd1);
    check_eq("rst_move", 32'(should_move), 32'd0);
    check_eq("rst_door", 32'(door_open), 32'd0);

    // Scenario 1: inside call at floor 3 from floor 0
    req(3, 0);
    check_eq("s1_latch", 32'(call_inside), 32'h08);
    check_eq("s1_still_idle", 32'(state_out), 32'd0);
    tick();
    check_eq("s1_moving", 32'(state_out), 32'd1);
    check_eq("s1_dir_up", 32'(direction), 32'd1);
    check_eq("s1_move", 32'(should_move), 32'd1);
    arr(2);
    check_eq("s1_pass2", 32'(state_out), 32'd1);
    arr(3);
    check_eq("s1_door", 32'(state_out), 32'd2);
    check_eq("s1_clr", 32'(call_inside), 32'd0);
    check_eq("s1_door_open", 32'(door_open), 32'd1);
    check_eq("s1_move_off", 32'(should_move), 32'd0);
    for (int i = 0; i < DOOR_TICKS - 1; i++) begin
      tick();
      check_eq("s1_dwell", 32'(door_open), 32'd1);
    end
    tick();
    check_eq("s1_door_closed", 32'(door_open), 32'd0);
    check_eq("s1_idle", 32'(state_out), 32'd0);
    check_eq("s1_idle_move", 32'(should_move), 32'd0);

    // Scenario 2: SCAN order up@5, down@4 (passed), inside@1
    cur_floor = FLOOR_W'(2);
    req(5, 1);
    req(4, 2);
    req(1, 0);
    check_eq("s2_in", 32'(call_inside), 32'h02);
    check_eq("s2_up", 32'(call_up), 32'h20);
    check_eq("s2_dn", 32'(call_down), 32'h10);
    check_eq("s2_dir_up", 32'(direction), 32'd1);
    check_eq("s2_moving", 32'(state_out), 32'd1);
    arr(3);
    arr(4);
    check_eq("s2_pass4", 32'(state_out), 32'd1);
    arr(5);
    check_eq("s2_stop5", 32'(state_out), 32'd2);
    check_eq("s2_up_clr", 32'(call_up), 32'd0);
    check_eq("s2_flip_dn", 32'(direction), 32'd0);
    for (int i = 0; i < DOOR_TICKS; i++) tick();
    check_eq("s2_idle5", 32'(state_out), 32'd0);
    tick();
    check_eq("s2_move_dn", 32'(state_out), 32'd1);
    check_eq("s2_dir_dn", 32'(direction), 32'd0);
    arr(4);
    check_eq("s2_stop4", 32'(state_out), 32'd2);
    check_eq("s2_dn_clr", 32'(call_down), 32'd0);
    check_eq("s2_keep_dn", 32'(direction), 32'd0);
    for (int i = 0; i < DOOR_TICKS; i++) tick();
    tick();
    check_eq("s2_move_dn2", 32'(state_out), 32'd1);
    arr(3);
    arr(2);
    check_eq("s2_pass2", 32'(state_out), 32'd1);
    arr(1);
    check_eq("s2_stop1", 32'(state_out), 32'd2);
    check_eq("s2_flip_up", 32'(direction), 32'd1);
    for (int i = 0; i < DOOR_TICKS; i++) tick();
    check_eq("s2_end_idle", 32'(state_out), 32'd0);
    check_eq("s2_all_clear", 32'(call_inside | call_up | call_down), 32'd0);

    // Scenario 3: invalid requests are dropped
    req(7, 1);
    req(0, 2);
    req(9, 0);
    req(3, 3);
    check_eq("s3_calls", 32'(call_inside | call_up | call_down), 32'd0);
    tick();
    check_eq("s3_idle", 32'(state_out), 32'd0);

    // Scenario 4: request at the served floor reloads the dwell
    cur_floor = FLOOR_W'(2);
    req(2, 0);
    check_eq("s4_latch", 32'(call_inside), 32'h04);
    tick();
    check_eq("s4_door", 32'(state_out), 32'd2);
    tick();
    tick();
    tick();
    req(2, 0);
    check_eq("s4_reload_door", 32'(state_out), 32'd2);
    check_eq("s4_not_latched", 32'(call_inside), 32'd0);
    req(6, 1);
    check_eq("s4_up6", 32'(call_up), 32'h40);
    tick();
    tick();
    check_eq("s4_still_open", 32'(door_open), 32'd1);
    tick();
    check_eq("s4_closed", 32'(door_open), 32'd0);
    check_eq("s4_idle", 32'(state_out), 32'd0);
    tick();
    check_eq("s4_moving", 32'(state_out), 32'd1);
    check_eq("s4_dir_up", 32'(direction), 32'd1);
    check_eq("s4_move", 32'(should_move), 32'd1);
    arr(6);
    check_eq("s4_stop6", 32'(state_out), 32'd2);
    check_eq("s4_up_clr", 32'(call_up), 32'd0);

    // Scenario 5: idle at 4 heading up, only down@1 pending
    cur_floor = FLOOR_W'(4);
    do_reset();
    req(1, 2);
    check_eq("s5_latch", 32'(call_down), 32'h02);
    tick();
    check_eq("s5_moving", 32'(state_out), 32'd1);
    check_eq("s5_flip_dn", 32'(direction), 32'd0);
    arr(3);
    arr(2);
    arr(1);
    check_eq("s5_stop1", 32'(state_out), 32'd2);
    check_eq("s5_dn_clr", 32'(call_down), 32'd0);

    // Scenario 6: asynchronous reset while moving with three calls
    cur_floor = FLOOR_W'(0);
    do_reset();
    req(3, 0);
    req(5, 1);
    req(6, 2);
    check_eq("s6_moving", 32'(state_out), 32'd1);
    check_eq("s6_pending", 32'(call_inside | call_up | call_down), 32'h68);
    reset = 1'b1;
    #1;
    check_eq("s6_calls", 32'(call_inside | call_up | call_down), 32'd0);
    check_eq("s6_move", 32'(should_move), 32'd0);
    check_eq("s6_state", 32'(state_out), 32'd0);
    check_eq("s6_dir", 32'(direction), 32'd1);
    tick();
    reset = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
